// File: rtl/shift_unit_seq.sv
// shift_unit_seq: sequential 16-bit shifter (SLL / SRA / ROR).
// An accepted start captures the operand, amount and mode. The operand is then
// shifted one bit per clock until the count reaches zero, and the result is
// published on shift_out with a one-cycle done pulse.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | nothing pending, shift_out holds last result, start accepted
// SHIFT  | one bit shifted per cycle, busy high, start ignored
// DONE   | done pulse, shift_out valid, start accepted (back-to-back)

module shift_unit_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] shift_in,
    input  logic [3:0]  shift_val,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic [15:0] shift_out
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_data;
    logic [3:0]  r_cnt;
    logic [1:0]  r_mode;
    logic [15:0] r_shift_out;

    logic        w_accept;
    logic        w_direct;
    logic        w_last_step;
    logic [15:0] w_step;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, start acceptance and status outputs
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_direct    = 1'b0;
        w_last_step = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if ((shift_val == 4'd0) || (mode == MODE_RSV)) begin
                        w_direct    = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                // Count is never zero here; the <= guard only keeps a
                // corrupted count from wedging the FSM in SHIFT.
                if (r_cnt <= 4'd1) begin
                    w_last_step = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    if ((shift_val == 4'd0) || (mode == MODE_RSV)) begin
                        w_direct    = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One-bit step of the captured operand according to the captured mode
    always_comb begin
        w_step = r_data;
        case (r_mode)
            MODE_SLL: w_step = {r_data[14:0], 1'b0};
            MODE_SRA: w_step = {r_data[15], r_data[15:1]};
            MODE_ROR: w_step = {r_data[0], r_data[15:1]};
            MODE_RSV: w_step = r_data;
            default:  w_step = r_data;
        endcase
    end

    // Operand capture and per-cycle shift / count-down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= 16'h0000;
            r_cnt  <= 4'd0;
            r_mode <= 2'b00;
        end else if (w_accept) begin
            r_data <= shift_in;
            r_cnt  <= shift_val;
            r_mode <= mode;
        end else if (r_state == ST_SHIFT) begin
            r_data <= w_step;
            r_cnt  <= r_cnt - 4'd1;
        end
    end

    // Result register: loaded only on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_out <= 16'h0000;
        end else if (w_direct) begin
            // Zero amount or reserved mode: operand passes through unshifted.
            r_shift_out <= shift_in;
        end else if (w_last_step) begin
            r_shift_out <= w_step;
        end
    end

    assign shift_out = r_shift_out;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: the driver pushes expected result and
// done-edge for every issued operation, a negedge monitor pops on done.
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] shift_in = 16'h0000;
    logic [3:0]  shift_val = 4'd0;
    logic [1:0]  mode = 2'b00;
    logic        busy;
    logic        done;
    logic [15:0] shift_out;

    shift_unit_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .shift_in  (shift_in),
        .shift_val (shift_val),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .shift_out (shift_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] res;
        int          edge_n;
    } exp_t;

    exp_t        sb_q[$];
    int          busy_lo = 0;
    int          busy_hi = 0;
    logic [15:0] last_res = 16'h0000;

    function automatic logic [15:0] ref_model(input logic [15:0] d, input int v, input logic [1:0] m);
        logic [31:0] w;
        case (m)
            2'b00: return d << v;
            2'b01: return 16'($signed(d) >>> v);
            2'b10: begin
                w = {d, d} >> v;
                return w[15:0];
            end
            default: return d;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: busy window and done/result against the scoreboard
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            check("busy", 32'(busy), 32'((cyc >= busy_lo) && (cyc < busy_hi)));
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_edge", cyc, e.edge_n);
                    check("result", 32'(shift_out), 32'(e.res));
                end
            end else if ((sb_q.size() > 0) && (sb_q[0].edge_n <= cyc)) begin
                e = sb_q.pop_front();
                check("missing_done", 32'(done), 32'd1);
            end
        end
    end

    // Called at a negedge with the DUT in IDLE or DONE; returns at the
    // negedge where the DUT shows DONE for this operation.
    task automatic do_op(input logic [15:0] d, input int v, input logic [1:0] m, input bit garbage);
        int lat;
        lat = ((v == 0) || (m == 2'b11)) ? 0 : v;
        shift_in  = d;
        shift_val = 4'(v);
        mode      = m;
        start     = 1'b1;
        sb_q.push_back('{ref_model(d, v, m), cyc + 1 + lat});
        busy_lo  = cyc + 1;
        busy_hi  = cyc + 1 + lat;
        last_res = ref_model(d, v, m);
        @(negedge clk);
        for (int j = 1; j <= lat; j++) begin
            start     = garbage ? 1'($urandom) : 1'b0;
            shift_in  = 16'($urandom);
            shift_val = 4'($urandom);
            mode      = 2'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("hold", 32'(shift_out), 32'(last_res));
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [15:0] d;
        int          v;
        logic [1:0]  m;
        int          wait_n;

        // Power-on reset, checked before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_shift_out", 32'(shift_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // First start right after release
        do_op(16'h0001, 4, 2'b00, 1'b0);
        idle(2);

        do_op(16'h8000, 15, 2'b01, 1'b0);
        do_op(16'h4000, 1, 2'b01, 1'b0);
        idle(1);

        do_op(16'h00F1, 4, 2'b10, 1'b0);
        for (int k = 0; k < 4; k++) begin
            do_op(16'($urandom), 0, 2'(k), 1'b0);
        end
        do_op(16'hC3A5, 7, 2'b11, 1'b0);
        idle(2);

        // Ignored mid-shift starts, then back-to-back from DONE
        do_op(16'hBEEF, 9, 2'b10, 1'b1);
        do_op(16'h1357, 5, 2'b00, 1'b0);
        idle(3);

        // Asynchronous reset in the third SHIFT cycle of a 10-bit shift
        shift_in  = 16'h1234;
        shift_val = 4'd10;
        mode      = 2'b00;
        start     = 1'b1;
        busy_lo   = cyc + 1;
        busy_hi   = cyc + 11;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        busy_lo = 0;
        busy_hi = 0;
        #1;
        check("async_rst_shift_out", 32'(shift_out), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        last_res = 16'h0000;
        idle(20);

        do_op(16'hF00F, 3, 2'b01, 1'b0);
        idle(1);

        // Randomized operations
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 5))
                0: d = 16'h0000;
                1: d = 16'hFFFF;
                2: d = 16'h8000;
                3: d = 16'h0001;
                default: d = 16'($urandom);
            endcase
            v = $urandom_range(0, 15);
            m = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            do_op(d, v, m, 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                wait_n = $urandom_range(0, 3);
                idle(wait_n);
            end
        end

        // Drain outstanding expectations with a bounded wait
        for (int i = 0; (i < 40) && (sb_q.size() > 0); i++) begin
            @(negedge clk);
        end
        check("drain", sb_q.size(), 32'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_unit_seq.md
SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 16 bits and shift amount at 4 bits.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; SHALL be sampled only on a rising edge while the block is in IDLE or DONE.
REQ-005 shift_in  input  16  operand, captured on an accepted start.
REQ-006 shift_val  input  4  shift amount 0..15, captured on an accepted start.
REQ-007 mode  input  2  operation, captured on an accepted start:
  - 00 = SLL
  - 01 = SRA
  - 10 = ROR
  - 11 = reserved
REQ-008 busy  output  1  high while an operation is in progress (SHIFT state).
REQ-009 done  output  1  single-cycle pulse marking a valid shift_out.
REQ-010 shift_out  output  16  result register; SHALL hold its value until the next accepted start completes.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 On an accepted start, the block SHALL load data_reg=shift_in, cnt=shift_val and mode_reg=mode.
REQ-013 On an accepted start with cnt==0 or mode==11, next state SHALL be DONE; otherwise next state SHALL be SHIFT.
REQ-014 Each SHIFT cycle SHALL shift data_reg by exactly one bit and decrement cnt:
  - SLL: zero fill into bit 0.
  - SRA: bit 15 replicated into bit 15.
  - ROR: bit 0 moved to bit 15.
REQ-015 SHIFT SHALL transition to DONE on the edge where cnt decrements from 1 to 0; otherwise it SHALL remain in SHIFT.
REQ-016 On entry to DONE, shift_out SHALL be updated with the final data_reg value.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle and busy SHALL be 0.
REQ-018 Latency: start sampled at edge N SHALL produce done=1 in the cycle following edge N+shift_val (mode 11: following edge N).
REQ-019 mode 11 SHALL produce shift_out=shift_in, with no shift applied.
REQ-020 start asserted while in SHIFT SHALL be ignored: no re-capture and no effect on the result.
REQ-021 start asserted during DONE SHALL be accepted (back-to-back operation); with no start, DONE SHALL go to IDLE.
REQ-022 When no operation is pending, done SHALL be 0 and shift_out SHALL hold its last result.
REQ-023 Result SHALL equal the combinational reference:
  - SLL: shift_in << shift_val.
  - SRA: $signed(shift_in) >>> shift_val.
  - ROR: shift_in rotated right by shift_val.
REQ-024 Input changes on shift_in, shift_val and mode after capture SHALL NOT affect an in-flight operation.

Reset
REQ-025 rst_n low SHALL immediately, without waiting for clk:
  - set state=IDLE
  - set busy=0, done=0, shift_out=16'h0000
  - clear data_reg, cnt and mode_reg
REQ-026 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-027 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-028 SLL: shift_in=16'h0001, shift_val=4, mode=00 -> busy high for 4 cycles; done in the 5th cycle; shift_out=16'h0010.
REQ-029 SRA: shift_in=16'h8000, shift_val=15, mode=01 -> shift_out=16'hFFFF, done 16 cycles after start. Also shift_in=16'h4000, val=1 -> 16'h2000.
REQ-030 ROR and zero shift:
  - shift_in=16'h00F1, val=4, mode=10 -> 16'h100F.
  - val=0 with any mode -> done on the next cycle, shift_out=shift_in, busy never high.
REQ-031 Ignored start / back-to-back: start re-pulsed mid-SHIFT with new operands -> first result unchanged. Then start asserted during DONE -> second operation completes with the correct second result and a second done pulse.
REQ-032 Reset mid-op: rst_n low asynchronously at SHIFT cycle 3 of a val=10 operation -> outputs zero immediately; no done after release.
REQ-033 Exhaustive: all 65536 shift_in x 16 shift_val x modes 00/01/10, each checked against REQ-023 at done; any mismatch is a failure.
